key_expand_ctrl: RTL
====================

# key_expand_ctrl

Sequencer for the 128-bit AES key-schedule datapath (one round of expansion per invocation, pipelined, no handshake of its own). It accepts a cipher key, drives the schedule round by round with the current key and round number, and feeds each result back as the next input. It stores all 11 round keys in a local register file and serves them to the cipher round logic through a registered read port.

## Interface
- KS_LATENCY, 5, clock edges from a `ks_key`/`ks_rnd` change until `ks_key_out` is valid; must be ≥1
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  128  cipher key
- key_valid  in  1  `key_in` is valid
- key_ready  out  1  controller can accept a key; equals (state==IDLE)
- ks_key  out  128  to schedule key input; held stable for a whole round
- ks_rnd  out  4  to schedule round-number input; 0..9
- ks_key_out  in  128  next round key from the schedule
- rk_rd_idx  in  4  round-key read index, 0..10
- rk_rd_data  out  128  round key `rk[rk_rd_idx]`, registered
- keys_valid  out  1  all 11 round keys in `rk` belong to the last accepted key
- busy  out  1  expansion in progress (state==RUN)
- done  out  1  single-cycle pulse when expansion completes

## Operation
- States:
  - IDLE: `key_valid & key_ready` → RUN.
  - RUN: capture on `cnt==KS_LATENCY`. If `ks_rnd==9`, go to DONE; otherwise stay in RUN.
  - DONE → IDLE unconditionally.
- Accept edge:
  - `rk[0]<=key_in`, `ks_key<=key_in`, `ks_rnd<=0`, `cnt<=0`, `keys_valid<=0`.
- RUN:
  - `cnt` increments every edge.
  - At `cnt==KS_LATENCY`: `rk[ks_rnd+1]<=ks_key_out`, `ks_key<=ks_key_out`, `ks_rnd<=ks_rnd+1`, `cnt<=0`.
  - `ks_key` and `ks_rnd` change only on accept or capture edges.
- Final capture (`ks_rnd==9`):
  - state→DONE, `done<=1`, `keys_valid<=1`.
  - `ks_rnd` saturates at 9; it does not wrap to 10.
- DONE: `done<=0`, state→IDLE.
- `key_valid` outside IDLE is ignored; no queuing.
- Read port:
  - `rk_rd_data<=rk[rk_rd_idx]` every edge, in any state.
  - Index 11..15 returns 0.
  - Reads during RUN return partially updated contents; consumers qualify with `keys_valid`.
- `cnt` width is clog2(KS_LATENCY+1) and never exceeds KS_LATENCY.
- Reset (any state, including mid-expansion), all on the reset edge:
  - state=IDLE; `key_ready=1` in the following cycle.
  - `busy=0`, `done=0`, `keys_valid=0`.
  - `ks_key=0`, `ks_rnd=0`, `cnt=0`.
  - `rk[0..10]=0`, `rk_rd_data=0`.

## Timing
- Accept at edge A.
- Round i (i=0..9) captures at edge A+(i+1)(KS_LATENCY+1).
- Last capture at A+10(KS_LATENCY+1), i.e. A+60 for default KS_LATENCY=5.
- `done` and `keys_valid` rise in the cycle after edge A+60; `done` falls, and `key_ready` rises, after A+61.
- Earliest next accept is edge A+62; back-to-back period is 10(KS_LATENCY+1)+2 cycles.
- `busy` is high from the cycle after A through the cycle ending at A+60.
- Read latency is 1 cycle: `rk_rd_idx` sampled at edge E appears on `rk_rd_data` after E.

## Configuration
- Macro `KEYCTL_SAME_KEY_BYPASS_EN`.
- Defined:
  - On accept with `keys_valid==1` and `key_in==rk[0]`: go directly to DONE.
  - `done` pulses in the cycle after the accept edge.
  - `keys_valid` stays 1; `ks_key`, `ks_rnd` and `rk` are unchanged; `busy` stays 0.
  - Any other accept performs the full expansion.
- Undefined:
  - No comparator; every accept performs the full expansion and clears `keys_valid`.

## Test plan
- Reset, then accept key 2b7e151628aed2a6abf7158809cf4f3c at edge A → `done` pulses exactly after A+60, `keys_valid=1`.
  - Read idx 1 → a0fafe1788542cb123a339392a6c7605.
  - Read idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `ks_rnd` sequences 0..9, each value held for 6 cycles.
- Assert rst at A+25 → next cycle `busy=0`, `keys_valid=0`, `rk` reads all 0, `key_ready=1`. Re-accept the same key → correct `rk[10]` at A'+60.
- Hold `key_valid=1` with a different key throughout RUN → ignored. After DONE, a second accept occurs at A+62 and `rk[0]` takes the new value.
- Read idx 11 and idx 15 → 0. Read idx 0 while busy → the newly accepted key.
- With `KEYCTL_SAME_KEY_BYPASS_EN`, re-accept the identical key → `done` the next cycle, `busy` never asserts, `rk[10]` unchanged. With a different key → full 60-cycle expansion. Without the macro, the identical key → full 60-cycle expansion.
- Parameter KS_LATENCY=1, FIPS key above → `done` after A+20, `rk[10]` correct.

Source files
------------

// File: rtl/key_expand_ctrl.sv
// Sequencer for a pipelined AES-128 key-schedule datapath; keeps all 11 round keys and serves them via a registered read port.
// Optional macro KEYCTL_SAME_KEY_BYPASS_EN: re-accepting the key already expanded skips straight to DONE.
module key_expand_ctrl #(
  parameter int KS_LATENCY = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] ks_key,
  output logic [3:0]   ks_rnd,
  input  logic [127:0] ks_key_out,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
  output logic         keys_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(KS_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [127:0]   r_ks_key;
  logic [3:0]     r_ks_rnd;
  logic [127:0]   r_rk [0:10];
  logic [127:0]   r_rd_data;
  logic           r_keys_valid;
  logic           r_done;
  logic           w_accept;
  logic           w_bypass;
  logic           w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bypass    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          w_accept = 1'b1;
`ifdef KEYCTL_SAME_KEY_BYPASS_EN
          w_bypass = r_keys_valid && (key_in == r_rk[0]);
`endif
          w_state_nxt = w_bypass ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(KS_LATENCY)) begin
          w_capture = 1'b1;
          if (r_ks_rnd == 4'd9) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ks_key     <= '0;
      r_ks_rnd     <= '0;
      r_rd_data    <= '0;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= 1'b0;
      // Indices past the last round key read as zero rather than aliasing.
      r_rd_data <= (rk_rd_idx <= 4'd10) ? r_rk[rk_rd_idx] : '0;
      if (w_accept) begin
        if (w_bypass) begin
          r_done <= 1'b1;
        end else begin
          r_rk[0]      <= key_in;
          r_ks_key     <= key_in;
          r_ks_rnd     <= '0;
          r_cnt        <= '0;
          r_keys_valid <= 1'b0;
        end
      end else if (r_state == RUN) begin
        if (w_capture) begin
          r_rk[r_ks_rnd + 4'd1] <= ks_key_out;
          r_ks_key              <= ks_key_out;
          r_cnt                 <= '0;
          // ks_rnd holds at 9 after the final capture instead of wrapping to 10.
          if (r_ks_rnd == 4'd9) begin
            r_done       <= 1'b1;
            r_keys_valid <= 1'b1;
          end else begin
            r_ks_rnd <= r_ks_rnd + 4'd1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign key_ready  = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign ks_key     = r_ks_key;
  assign ks_rnd     = r_ks_rnd;
  assign rk_rd_data = r_rd_data;

endmodule
